// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the seq_store sequence memory
// Contents:
//   state_e    controller states IDLE / PLAY / CHECK
//   SEQ_DEPTH  default maximum sequence length (symbols)
//   SEQ_SYM_W  default bits per symbol
//   len_w()    width of a counter able to hold 0..depth
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam int SEQ_DEPTH = 16;
   localparam int SEQ_SYM_W = 4;

   function automatic int len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/seq_mem.sv
// rtl/seq_mem.sv - DEPTH x SYM_W symbol register array, sync write/clear, async read
// Optional build macro: SEQ_FLAT_OUT_EN adds the flattened seq_o view.
// Ports:
//   clk_i    rising-edge clock
//   clr_i    synchronous clear of every entry (active-high)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  combinational read address
//   rdata_o  combinational read data
//   seq_o    (SEQ_FLAT_OUT_EN only) entry i at seq_o[i*SYM_W +: SYM_W]
module seq_mem
   import seq_pkg::*;
#(
   parameter int  DEPTH = SEQ_DEPTH,
   parameter int  SYM_W = SEQ_SYM_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [SYM_W-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [SYM_W-1:0] rdata_o
`ifdef SEQ_FLAT_OUT_EN
   ,
   output logic [DEPTH*SYM_W-1:0] seq_o
`endif
);

   logic [SYM_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

`ifdef SEQ_FLAT_OUT_EN
   // Entries are only written at the append position and cleared as a whole,
   // so slots at or beyond the current length are already zero here.
   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign seq_o[g*SYM_W +: SYM_W] = mem_q[g];
   end
`endif

endmodule

// File: rtl/seq_store.sv
// rtl/seq_store.sv - Genius sequence store: append, ready/valid playback, player check
// Optional build macro: SEQ_FLAT_OUT_EN adds output seq_o [DEPTH*SYM_W-1:0].
// Ports:
//   CLK, R             clock, synchronous active-high reset
//   clr                empty the sequence (same effect as R)
//   app_v, app_sym     append request / symbol
//   play_start         begin playback (IDLE, len>0)
//   play_rdy           consumer accepts play_sym
//   play_v, play_sym   playback symbol valid / value
//   play_last          current playback symbol is the final one
//   chk_start          begin checking (IDLE, len>0)
//   chk_v, chk_sym     player symbol valid / value
//   chk_ok, chk_err    registered pulses: player symbol matched / mismatched
//   round_done         registered pulse: whole sequence matched
//   ovf_o              registered pulse: append attempted while full
//   len_o, full_o      current length, length == DEPTH
//   busy_o             state is not IDLE
//   seq_o              (SEQ_FLAT_OUT_EN only) flattened storage, entry 0 at LSBs
module seq_store
   import seq_pkg::*;
#(
   parameter int  DEPTH = SEQ_DEPTH,
   parameter int  SYM_W = SEQ_SYM_W,
   localparam int LEN_W = len_w(DEPTH)
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             clr,
   input  logic             app_v,
   input  logic [SYM_W-1:0] app_sym,
   input  logic             play_start,
   input  logic             play_rdy,
   output logic             play_v,
   output logic [SYM_W-1:0] play_sym,
   output logic             play_last,
   input  logic             chk_start,
   input  logic             chk_v,
   input  logic [SYM_W-1:0] chk_sym,
   output logic             chk_ok,
   output logic             chk_err,
   output logic             round_done,
   output logic             ovf_o,
   output logic [LEN_W-1:0] len_o,
   output logic             full_o,
   output logic             busy_o
`ifdef SEQ_FLAT_OUT_EN
   ,
   output logic [DEPTH*SYM_W-1:0] seq_o
`endif
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] ptr_q, ptr_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             we;
   logic [SYM_W-1:0] rdata;
   logic             full;
   logic             at_last;

   assign full    = (len_q == LEN_W'(DEPTH));
   assign at_last = (ptr_q == len_q - LEN_W'(1));

   // Write address is the append position; it is only used while not full,
   // so it always fits in AW bits.
   seq_mem #(
      .DEPTH (DEPTH),
      .SYM_W (SYM_W)
   ) u_mem (
      .clk_i   (CLK),
      .clr_i   (R | clr),
      .we_i    (we),
      .waddr_i (len_q[AW-1:0]),
      .wdata_i (app_sym),
      .raddr_i (ptr_q[AW-1:0]),
      .rdata_o (rdata)
`ifdef SEQ_FLAT_OUT_EN
      ,
      .seq_o   (seq_o)
`endif
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      we      = 1'b0;

      if (clr) begin
         state_d = IDLE;
         len_d   = '0;
         ptr_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // app_v > play_start > chk_start; losers are dropped.
               if (app_v) begin
                  if (!full) begin
                     we    = 1'b1;
                     len_d = len_q + LEN_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (play_start) begin
                  if (len_q != '0) begin
                     state_d = PLAY;
                     ptr_d   = '0;
                  end
               end else if (chk_start) begin
                  if (len_q != '0) begin
                     state_d = CHECK;
                     ptr_d   = '0;
                  end
               end
            end
            PLAY: begin
               if (play_rdy) begin
                  if (at_last) begin
                     state_d = IDLE;
                     ptr_d   = '0;
                  end else begin
                     ptr_d = ptr_q + LEN_W'(1);
                  end
               end
            end
            CHECK: begin
               if (chk_v) begin
                  if (chk_sym == rdata) begin
                     ok_d = 1'b1;
                     if (at_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        ptr_d   = '0;
                     end else begin
                        ptr_d = ptr_q + LEN_W'(1);
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                     ptr_d   = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (R) begin
         state_q <= IDLE;
         len_q   <= '0;
         ptr_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign play_v     = (state_q == PLAY);
   assign play_sym   = play_v ? rdata : '0;
   assign play_last  = play_v & at_last;
   assign chk_ok     = ok_q;
   assign chk_err    = err_q;
   assign round_done = done_q;
   assign ovf_o      = ovf_q;
   assign len_o      = len_q;
   assign full_o     = full;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_seq_store.sv
// tb/tb_seq_store.sv - self-checking bench for seq_store against a queue-based model
module tb_seq_store;

   localparam int DEPTH = 16;
   localparam int SYM_W = 4;
   localparam int LEN_W = $clog2(DEPTH + 1);

   logic             CLK = 1'b0;
   logic             R = 1'b1;
   logic             clr = 1'b0;
   logic             app_v = 1'b0;
   logic [SYM_W-1:0] app_sym = '0;
   logic             play_start = 1'b0;
   logic             play_rdy = 1'b0;
   logic             play_v;
   logic [SYM_W-1:0] play_sym;
   logic             play_last;
   logic             chk_start = 1'b0;
   logic             chk_v = 1'b0;
   logic [SYM_W-1:0] chk_sym = '0;
   logic             chk_ok;
   logic             chk_err;
   logic             round_done;
   logic             ovf_o;
   logic [LEN_W-1:0] len_o;
   logic             full_o;
   logic             busy_o;
`ifdef SEQ_FLAT_OUT_EN
   logic [DEPTH*SYM_W-1:0] seq_o;
`endif

   seq_store #(.DEPTH(DEPTH), .SYM_W(SYM_W)) dut (
      .CLK        (CLK),
      .R          (R),
      .clr        (clr),
      .app_v      (app_v),
      .app_sym    (app_sym),
      .play_start (play_start),
      .play_rdy   (play_rdy),
      .play_v     (play_v),
      .play_sym   (play_sym),
      .play_last  (play_last),
      .chk_start  (chk_start),
      .chk_v      (chk_v),
      .chk_sym    (chk_sym),
      .chk_ok     (chk_ok),
      .chk_err    (chk_err),
      .round_done (round_done),
      .ovf_o      (ovf_o),
      .len_o      (len_o),
      .full_o     (full_o),
      .busy_o     (busy_o)
`ifdef SEQ_FLAT_OUT_EN
      ,
      .seq_o      (seq_o)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the stored sequence as a queue, a mode and a cursor.
   int mq[$];
   int mode = 0;          // 0 idle, 1 playing, 2 checking
   int idx  = 0;
   bit e_ok, e_err, e_done, e_ovf;

   bit chk_en = 1'b0;
   bit rec    = 1'b0;
   int obs_sym[$];
   int obs_last[$];
   int n_ok, n_err, n_done, n_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      int sz;
      logic [63:0] flat;
      sz = mq.size();
      check("play_v", 64'(play_v), 64'(mode == 1));
      check("play_sym", 64'(play_sym), (mode == 1) ? 64'(mq[idx]) : 64'd0);
      check("play_last", 64'(play_last), 64'((mode == 1) && (idx == sz - 1)));
      check("len_o", 64'(len_o), 64'(sz));
      check("full_o", 64'(full_o), 64'(sz == DEPTH));
      check("busy_o", 64'(busy_o), 64'(mode != 0));
      check("chk_ok", 64'(chk_ok), 64'(e_ok));
      check("chk_err", 64'(chk_err), 64'(e_err));
      check("round_done", 64'(round_done), 64'(e_done));
      check("ovf_o", 64'(ovf_o), 64'(e_ovf));
      flat = '0;
      for (int i = 0; i < sz; i++) flat = flat | (64'(mq[i]) << (i * SYM_W));
`ifdef SEQ_FLAT_OUT_EN
      check("seq_o", 64'(seq_o), flat);
`endif
   endtask

   task automatic model_step();
      e_ok = 0; e_err = 0; e_done = 0; e_ovf = 0;
      if (R || clr) begin
         mq.delete();
         mode = 0;
         idx  = 0;
      end else if (mode == 0) begin
         if (app_v) begin
            if (mq.size() < DEPTH) mq.push_back(int'(app_sym));
            else e_ovf = 1;
         end else if (play_start) begin
            if (mq.size() > 0) begin mode = 1; idx = 0; end
         end else if (chk_start) begin
            if (mq.size() > 0) begin mode = 2; idx = 0; end
         end
      end else if (mode == 1) begin
         if (play_rdy) begin
            if (idx == mq.size() - 1) mode = 0;
            else idx++;
         end
      end else begin
         if (chk_v) begin
            if (int'(chk_sym) == mq[idx]) begin
               e_ok = 1;
               if (idx == mq.size() - 1) begin e_done = 1; mode = 0; end
               else idx++;
            end else begin
               e_err = 1;
               mode  = 0;
            end
         end
      end
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic cyc();
      #1;
      if (chk_en) check_outputs();
      if (rec && play_v) begin
         obs_sym.push_back(int'(play_sym));
         obs_last.push_back(int'(play_last));
      end
      if (chk_ok) n_ok++;
      if (chk_err) n_err++;
      if (round_done) n_done++;
      if (ovf_o) n_ovf++;
      model_step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic append(input int s);
      app_v = 1'b1; app_sym = SYM_W'(s);
      cyc();
      app_v = 1'b0;
   endtask

   task automatic clear_counts();
      n_ok = 0; n_err = 0; n_done = 0; n_ovf = 0;
   endtask

   int rdy_pat[5] = '{1, 0, 0, 1, 1};
   int exp_play[5] = '{3, 1, 1, 1, 2};
   int chk_a[3] = '{3, 1, 2};
   int full_list[$];
   int last_pos;

   initial begin
      @(negedge CLK);
      R = 1'b1;
      cyc();
      R = 1'b0;
      chk_en = 1'b1;
      cyc();

      // Append 3,1,2
      append(3); append(1); append(2);
      cyc();
      check("len_after_3", 64'(len_o), 64'd3);
      check("full_after_3", 64'(full_o), 64'd0);
`ifdef SEQ_FLAT_OUT_EN
      check("seq_o_213", 64'(seq_o[11:0]), 64'h213);
`endif

      // Playback with a 2-cycle stall on entry 1
      play_start = 1'b1; cyc(); play_start = 1'b0;
      obs_sym.delete(); obs_last.delete();
      rec = 1'b1;
      for (int i = 0; i < 5; i++) begin
         play_rdy = rdy_pat[i][0];
         cyc();
      end
      rec = 1'b0; play_rdy = 1'b0;
      check("play_count", 64'(obs_sym.size()), 64'd5);
      for (int i = 0; i < 5 && i < obs_sym.size(); i++) begin
         check("play_seq", 64'(obs_sym[i]), 64'(exp_play[i]));
         check("play_last_seq", 64'(obs_last[i]), 64'(i == 4));
      end
      check("busy_after_play", 64'(busy_o), 64'd0);

      // Correct check 3,1,2
      clear_counts();
      chk_start = 1'b1; cyc(); chk_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_v = 1'b1; chk_sym = SYM_W'(chk_a[i]);
         cyc();
      end
      chk_v = 1'b0;
      cyc();
      check("ok_count", 64'(n_ok), 64'd3);
      check("done_count", 64'(n_done), 64'd1);

      // Wrong check 3,2
      clear_counts();
      chk_start = 1'b1; cyc(); chk_start = 1'b0;
      chk_v = 1'b1; chk_sym = 4'd3; cyc();
      chk_sym = 4'd2; cyc();
      chk_v = 1'b0;
      cyc();
      check("ok_then_err_ok", 64'(n_ok), 64'd1);
      check("ok_then_err_err", 64'(n_err), 64'd1);
      check("len_kept", 64'(len_o), 64'd3);
      check("idle_after_err", 64'(busy_o), 64'd0);

      // Fill to DEPTH, then overflow
      clr = 1'b1; cyc(); clr = 1'b0;
      full_list.delete();
      for (int i = 0; i < DEPTH; i++) begin
         full_list.push_back(int'($urandom_range(0, 15)));
         append(full_list[i]);
      end
      check("full_at_16", 64'(full_o), 64'd1);
      clear_counts();
      append(5);
      cyc();
      check("ovf_once", 64'(n_ovf), 64'd1);
      check("len_16", 64'(len_o), 64'd16);
      play_start = 1'b1; cyc(); play_start = 1'b0;
      obs_sym.delete(); obs_last.delete();
      rec = 1'b1; play_rdy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) cyc();
      rec = 1'b0; play_rdy = 1'b0;
      check("full_play_count", 64'(obs_sym.size()), 64'(DEPTH));
      last_pos = -1;
      for (int i = 0; i < obs_sym.size() && i < DEPTH; i++) begin
         check("full_play_sym", 64'(obs_sym[i]), 64'(full_list[i]));
         if (obs_last[i] != 0 && last_pos < 0) last_pos = i;
      end
      check("full_play_last_idx", 64'(last_pos), 64'(DEPTH - 1));

      // Priority and empty commands
      clr = 1'b1; cyc(); clr = 1'b0;
      play_start = 1'b1; cyc(); play_start = 1'b0;
      check("play_empty_ignored", 64'(busy_o), 64'd0);
      chk_start = 1'b1; cyc(); chk_start = 1'b0;
      check("chk_empty_ignored", 64'(busy_o), 64'd0);
      app_v = 1'b1; app_sym = 4'd7; play_start = 1'b1; chk_start = 1'b1;
      cyc();
      app_v = 1'b0; play_start = 1'b0; chk_start = 1'b0;
      check("prio_busy", 64'(busy_o), 64'd0);
      check("prio_len", 64'(len_o), 64'd1);

      // clr mid-PLAY at ptr=2
      append(8); append(9);
      play_start = 1'b1; cyc(); play_start = 1'b0;
      play_rdy = 1'b1; cyc(); cyc();
      play_rdy = 1'b0;
      check("play_ptr2_sym", 64'(play_sym), 64'd9);
      clr = 1'b1; cyc(); clr = 1'b0;
      check("clr_play_v", 64'(play_v), 64'd0);
      check("clr_len", 64'(len_o), 64'd0);
      check("clr_busy", 64'(busy_o), 64'd0);

      // R mid-CHECK with a matching symbol presented
      append(4); append(5);
      chk_start = 1'b1; cyc(); chk_start = 1'b0;
      chk_v = 1'b1; chk_sym = 4'd4; cyc();
      R = 1'b1; chk_sym = 4'd5; cyc();
      R = 1'b0; chk_v = 1'b0;
      check("rst_chk_ok", 64'(chk_ok), 64'd0);
      check("rst_chk_err", 64'(chk_err), 64'd0);
      check("rst_len", 64'(len_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         R          = ($urandom_range(0, 199) == 0);
         clr        = ($urandom_range(0, 59) == 0);
         app_v      = ($urandom_range(0, 3) == 0);
         app_sym    = SYM_W'($urandom_range(0, 15));
         play_start = ($urandom_range(0, 9) == 0);
         chk_start  = ($urandom_range(0, 9) == 0);
         play_rdy   = ($urandom_range(0, 1) == 0);
         chk_v      = ($urandom_range(0, 1) == 0);
         if (mode == 2 && $urandom_range(0, 3) != 0) chk_sym = SYM_W'(mq[idx]);
         else chk_sym = SYM_W'($urandom_range(0, 15));
         cyc();
      end
      R = 1'b0; clr = 1'b0; app_v = 1'b0; play_start = 1'b0;
      chk_start = 1'b0; play_rdy = 1'b0; chk_v = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
